// File: rtl/vigna_mext_dispatch.sv
// RV32M dispatch: decodes M-extension ops, drives the multiply/divide coprocessor
// handshake and hands the result to writeback. Optional abort timer: COPROC_TIMEOUT_EN.
module vigna_mext_dispatch #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid,
  input  logic [31:0] ex_instr,
  input  logic [31:0] ex_rs1,
  input  logic [31:0] ex_rs2,
  output logic        ex_is_mext,
  output logic        ex_ready,
  output logic        busy,
  output logic        cp_valid,
  output logic [2:0]  cp_func,
  output logic [31:0] cp_op1,
  output logic [31:0] cp_op2,
  input  logic        cp_ready,
  input  logic [31:0] cp_result,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_WB    = 2'd3;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MUL = 7'b0000001;

  logic [1:0] state;
  logic       rd_nonzero;
  logic       cp_done;
  logic       timeout_hit;

  // Register-source fields are consumed upstream; only opcode/funct/rd matter here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^ex_instr[24:15];

  assign ex_is_mext = (ex_instr[6:0] == OPC_OP) && (ex_instr[31:25] == FUNCT7_MUL);
  assign ex_ready   = (state == S_IDLE) && ex_valid && ex_is_mext;
  assign busy       = (state != S_IDLE);
  assign rd_nonzero = (wb_rd != 5'd0);
  assign cp_done    = (state == S_WAIT) && cp_ready;

`ifdef COPROC_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;

  // NOTE: sequential state is always written with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wait_cnt <= '0;
    end else if (state != S_WAIT) begin
      wait_cnt <= '0;
    end else if (!cp_ready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // A cp_ready arriving on the limit cycle takes priority over the abort.
  assign timeout_hit = (state == S_WAIT) && !cp_ready && (wait_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wb_err <= 1'b0;
    end else if (timeout_hit) begin
      wb_err <= rd_nonzero;
    end else if (state == S_WB && wb_ready) begin
      wb_err <= 1'b0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign wb_err      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_IDLE;
      cp_valid <= 1'b0;
      cp_func  <= 3'd0;
      cp_op1   <= 32'd0;
      cp_op2   <= 32'd0;
      wb_valid <= 1'b0;
      wb_rd    <= 5'd0;
      wb_data  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ex_ready) begin
            cp_func  <= ex_instr[14:12];
            cp_op1   <= ex_rs1;
            cp_op2   <= ex_rs2;
            wb_rd    <= ex_instr[11:7];
            cp_valid <= 1'b1;
            state    <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          state <= S_WAIT;
        end

        S_WAIT: begin
          // cp_valid must drop at the capture edge: the coprocessor re-arms one
          // cycle after ready and would otherwise start a duplicate operation.
          if (cp_done) begin
            cp_valid <= 1'b0;
            wb_data  <= cp_result;
            wb_valid <= rd_nonzero;
            state    <= rd_nonzero ? S_WB : S_IDLE;
          end else if (timeout_hit) begin
            cp_valid <= 1'b0;
            wb_data  <= 32'hFFFF_FFFF;
            wb_valid <= rd_nonzero;
            state    <= rd_nonzero ? S_WB : S_IDLE;
          end
        end

        S_WB: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            state    <= S_IDLE;
          end
        end

        default: begin
          state    <= S_IDLE;
          cp_valid <= 1'b0;
          wb_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vigna_mext_dispatch.sv
// Directed bench for vigna_mext_dispatch; honours COPROC_TIMEOUT_EN with TIMEOUT_CYCLES=16.
module tb_vigna_mext_dispatch;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_valid;
  logic [31:0] ex_instr, ex_rs1, ex_rs2;
  logic        ex_is_mext, ex_ready, busy;
  logic        cp_valid;
  logic [2:0]  cp_func;
  logic [31:0] cp_op1, cp_op2;
  logic        cp_ready;
  logic [31:0] cp_result;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_err;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] I_MUL_X5   = 32'h0220_82B3;
  localparam logic [31:0] I_ADD_X5   = 32'h0020_82B3;
  localparam logic [31:0] I_MULHU_X3 = 32'h0220_B1B3;
  localparam logic [31:0] I_MUL_X0   = 32'h0220_8033;
  localparam logic [31:0] I_MUL_X7   = 32'h0220_83B3;
  localparam logic [31:0] I_DIV_X6   = 32'h0220_C333;

  vigna_mext_dispatch #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn),
    .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_is_mext(ex_is_mext), .ex_ready(ex_ready), .busy(busy),
    .cp_valid(cp_valid), .cp_func(cp_func), .cp_op1(cp_op1), .cp_op2(cp_op2),
    .cp_ready(cp_ready), .cp_result(cp_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one instruction for exactly one edge; caller must be in IDLE.
  task automatic issue(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
    ex_valid = 1'b1; ex_instr = instr; ex_rs1 = a; ex_rs2 = b;
    tick();
    ex_valid = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    tick(2);
    resetn = 1'b1;
    tick();
    n_checks++; if ({cp_valid, wb_valid, wb_err, busy} !== 4'b0000) begin n_fail++;
      $display("FAIL reset_flags: got %b want 0000", {cp_valid, wb_valid, wb_err, busy}); end
    n_checks++; if ({cp_func, cp_op1, cp_op2, wb_rd, wb_data} !== '0) begin n_fail++;
      $display("FAIL reset_regs: func=%h op1=%h op2=%h rd=%h data=%h want all 0",
               cp_func, cp_op1, cp_op2, wb_rd, wb_data); end
  endtask

  task automatic test_mul_basic;
    ex_valid = 1'b1; ex_instr = I_MUL_X5; ex_rs1 = 32'd7; ex_rs2 = 32'd6;
    #1;
    n_checks++; if ({ex_is_mext, ex_ready} !== 2'b11) begin n_fail++;
      $display("FAIL t1_accept: got is_mext/ready=%b want 11", {ex_is_mext, ex_ready}); end
    tick();
    ex_valid = 1'b0;
    n_checks++; if ({cp_valid, busy} !== 2'b11) begin n_fail++;
      $display("FAIL t1_cp_valid_latency: got valid/busy=%b want 11", {cp_valid, busy}); end
    n_checks++; if ({cp_func, cp_op1, cp_op2} !== {3'b000, 32'd7, 32'd6}) begin n_fail++;
      $display("FAIL t1_operands: got %b %0d %0d want 000 7 6", cp_func, cp_op1, cp_op2); end
    tick(3);
    cp_ready = 1'b1; cp_result = 32'd42;
    n_checks++; if (cp_valid !== 1'b1) begin n_fail++;
      $display("FAIL t1_cp_valid_held: got %b want 1", cp_valid); end
    tick();
    cp_ready = 1'b0; cp_result = 32'hDEAD_BEEF;
    n_checks++; if (cp_valid !== 1'b0) begin n_fail++;
      $display("FAIL t1_cp_valid_drop: got %b want 0", cp_valid); end
    n_checks++; if ({wb_valid, wb_rd, wb_data, wb_err} !== {1'b1, 5'd5, 32'd42, 1'b0}) begin n_fail++;
      $display("FAIL t1_wb: got v=%b rd=%0d data=%0d err=%b want v=1 rd=5 data=42 err=0",
               wb_valid, wb_rd, wb_data, wb_err); end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    n_checks++; if ({wb_valid, busy} !== 2'b00) begin n_fail++;
      $display("FAIL t1_wb_done: got valid/busy=%b want 00", {wb_valid, busy}); end
  endtask

  task automatic test_non_mext;
    ex_valid = 1'b1; ex_instr = I_ADD_X5; ex_rs1 = 32'd1; ex_rs2 = 32'd2;
    #1;
    n_checks++; if ({ex_is_mext, ex_ready} !== 2'b00) begin n_fail++;
      $display("FAIL t2_decode: got is_mext/ready=%b want 00", {ex_is_mext, ex_ready}); end
    tick(3);
    ex_valid = 1'b0;
    n_checks++; if ({cp_valid, busy} !== 2'b00) begin n_fail++;
      $display("FAIL t2_not_accepted: got valid/busy=%b want 00", {cp_valid, busy}); end
  endtask

  task automatic test_wb_backpressure;
    logic stable_ok = 1'b1;
    issue(I_MULHU_X3, 32'hFFFF_FFFF, 32'd2);
    n_checks++; if ({cp_func, cp_op1, cp_op2} !== {3'b011, 32'hFFFF_FFFF, 32'd2}) begin n_fail++;
      $display("FAIL t3_operands: got %b %h %0d want 011 ffffffff 2", cp_func, cp_op1, cp_op2); end
    tick();
    cp_ready = 1'b1; cp_result = 32'd1;
    tick();
    cp_ready = 1'b0; cp_result = 32'd0;
    // Offer another M op while writeback stalls; it must not be taken.
    ex_valid = 1'b1; ex_instr = I_MUL_X5; ex_rs1 = 32'd9; ex_rs2 = 32'd9;
    for (int i = 0; i < 5; i++) begin
      #0;
      if (wb_valid !== 1'b1 || wb_data !== 32'd1 || wb_rd !== 5'd3 || ex_ready !== 1'b0)
        stable_ok = 1'b0;
      tick();
    end
    n_checks++; if (stable_ok !== 1'b1) begin n_fail++;
      $display("FAIL t3_stall_stable: got ok=%b want 1 (v=%b rd=%0d data=%0d exr=%b)",
               stable_ok, wb_valid, wb_rd, wb_data, ex_ready); end
    wb_ready = 1'b1;
    #1;
    n_checks++; if (ex_ready !== 1'b0) begin n_fail++;
      $display("FAIL t3_no_accept_in_wb: got ex_ready=%b want 0", ex_ready); end
    tick();
    wb_ready = 1'b0;
    n_checks++; if ({wb_valid, busy, ex_ready} !== 3'b001) begin n_fail++;
      $display("FAIL t3_idle_after_wb: got valid/busy/ex_ready=%b want 001",
               {wb_valid, busy, ex_ready}); end
    ex_valid = 1'b0;
    tick();
  endtask

  task automatic test_rd_zero;
    logic no_wb = 1'b1;
    issue(I_MUL_X0, 32'd3, 32'd4);
    n_checks++; if (cp_valid !== 1'b1) begin n_fail++;
      $display("FAIL t4_cp_valid: got %b want 1", cp_valid); end
    tick();
    cp_ready = 1'b1; cp_result = 32'd12;
    tick();
    cp_ready = 1'b0;
    n_checks++; if ({busy, cp_valid, wb_valid} !== 3'b000) begin n_fail++;
      $display("FAIL t4_idle_no_wb: got busy/cp_valid/wb_valid=%b want 000",
               {busy, cp_valid, wb_valid}); end
    for (int i = 0; i < 4; i++) begin
      if (wb_valid !== 1'b0) no_wb = 1'b0;
      tick();
    end
    n_checks++; if (no_wb !== 1'b1) begin n_fail++;
      $display("FAIL t4_wb_stays_low: got ok=%b want 1", no_wb); end
  endtask

  task automatic test_reset_mid_op;
    issue(I_MUL_X5, 32'd8, 32'd8);
    tick(2);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    n_checks++; if ({cp_valid, wb_valid, busy} !== 3'b000) begin n_fail++;
      $display("FAIL t5_abandon: got cp_valid/wb_valid/busy=%b want 000",
               {cp_valid, wb_valid, busy}); end
    // Restart; a cp_ready during ISSUE must be ignored, the real one comes in WAIT.
    issue(I_MUL_X7, 32'd3, 32'd5);
    cp_ready = 1'b1; cp_result = 32'd99;
    tick();
    n_checks++; if ({cp_valid, wb_valid, busy} !== 3'b101) begin n_fail++;
      $display("FAIL t5_issue_ignores_ready: got cp_valid/wb_valid/busy=%b want 101",
               {cp_valid, wb_valid, busy}); end
    cp_result = 32'd15;
    tick();
    cp_ready = 1'b0;
    n_checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd7, 32'd15}) begin n_fail++;
      $display("FAIL t5_min_round_trip: got v=%b rd=%0d data=%0d want v=1 rd=7 data=15",
               wb_valid, wb_rd, wb_data); end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
  endtask

  task automatic test_timeout;
    logic held_ok = 1'b1;
`ifdef COPROC_TIMEOUT_EN
    issue(I_DIV_X6, 32'd100, 32'd0);
    tick();
    for (int i = 0; i < 16; i++) begin
      if (cp_valid !== 1'b1) held_ok = 1'b0;
      if (i < 15) tick();
    end
    n_checks++; if (held_ok !== 1'b1) begin n_fail++;
      $display("FAIL t6_valid_16_waits: got ok=%b want 1", held_ok); end
    tick();
    n_checks++; if ({cp_valid, wb_valid, wb_data, wb_err} !== {1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1}) begin
      n_fail++;
      $display("FAIL t6_abort: got cpv=%b wbv=%b data=%h err=%b want 0 1 ffffffff 1",
               cp_valid, wb_valid, wb_data, wb_err); end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    n_checks++; if ({wb_valid, wb_err, busy} !== 3'b000) begin n_fail++;
      $display("FAIL t6_err_clear: got v/err/busy=%b want 000", {wb_valid, wb_err, busy}); end
    // Ready on the limit cycle beats the abort.
    issue(I_DIV_X6, 32'd100, 32'd7);
    tick(16);
    cp_ready = 1'b1; cp_result = 32'd14;
    tick();
    cp_ready = 1'b0;
    n_checks++; if ({wb_valid, wb_data, wb_err} !== {1'b1, 32'd14, 1'b0}) begin n_fail++;
      $display("FAIL t6_ready_wins: got v=%b data=%0d err=%b want 1 14 0",
               wb_valid, wb_data, wb_err); end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
`else
    issue(I_DIV_X6, 32'd100, 32'd0);
    for (int i = 0; i < 1000; i++) begin
      if (busy !== 1'b1 || cp_valid !== 1'b1 || wb_err !== 1'b0) held_ok = 1'b0;
      tick();
    end
    n_checks++; if (held_ok !== 1'b1) begin n_fail++;
      $display("FAIL t6_wait_forever: got ok=%b want 1 (busy=%b cpv=%b)", held_ok, busy, cp_valid); end
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    n_checks++; if (busy !== 1'b0) begin n_fail++;
      $display("FAIL t6_recover: got busy=%b want 0", busy); end
`endif
  endtask

  initial begin
    resetn = 1'b0; ex_valid = 1'b0; ex_instr = '0; ex_rs1 = '0; ex_rs2 = '0;
    cp_ready = 1'b0; cp_result = '0; wb_ready = 1'b0;
    test_reset();
    test_mul_basic();
    test_non_mext();
    test_wb_backpressure();
    test_rd_zero();
    test_reset_mid_op();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vigna_mext_dispatch.md
Name: vigna_mext_dispatch

Overview:
- Sits between the core execute stage and the RV32M multiply/divide coprocessor; the block is upstream of the coprocessor.
- Decodes RV32M R-type instructions and latches the operands.
- Drives the coprocessor valid/ready handshake and holds the function code stable until the result is captured.
- Presents the result to writeback through its own valid/ready handshake.

Parameters:
- TIMEOUT_CYCLES, 256: maximum number of WAIT cycles before abort. Used only when COPROC_TIMEOUT_EN is defined; minimum value 2.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset.
- ex_valid  in  1  execute stage presents an instruction.
- ex_instr  in  32  instruction word.
- ex_rs1  in  32  rs1 value.
- ex_rs2  in  32  rs2 value.
- ex_is_mext  out  1  combinational: ex_instr is an RV32M op (opcode 0110011, funct7 0000001).
- ex_ready  out  1  instruction accepted this cycle.
- busy  out  1  state != IDLE.
- cp_valid  out  1  request to the coprocessor.
- cp_func  out  3  latched funct3.
- cp_op1  out  32  latched rs1 value.
- cp_op2  out  32  latched rs2 value.
- cp_ready  in  1  coprocessor done; single-cycle pulse.
- cp_result  in  32  coprocessor result; valid only while cp_ready=1 and cp_func is unchanged.
- wb_valid  out  1  result available for writeback.
- wb_ready  in  1  writeback accepts.
- wb_rd  out  5  destination register.
- wb_data  out  32  result.
- wb_err  out  1  result is an abort value.

Behaviour:
- Reset: resetn, synchronous, active-low; clock clk. On reset the state is IDLE and cp_valid, wb_valid, wb_err, cp_func, cp_op1, cp_op2, wb_rd and wb_data are all 0. Reset mid-operation abandons the transaction with no writeback. The coprocessor shares the same resetn.
- ex_ready = (state==IDLE) && ex_valid && ex_is_mext. Instructions that are not RV32M are never accepted.
- IDLE -> ISSUE on accept. Latch cp_func=ex_instr[14:12], cp_op1=ex_rs1, cp_op2=ex_rs2, wb_rd=ex_instr[11:7].
- ISSUE: cp_valid=1 on the cycle after accept. Go to WAIT unconditionally.
- WAIT: cp_valid stays 1 and cp_func/cp_op1/cp_op2 stay stable. When cp_ready=1 is sampled:
  - capture wb_data=cp_result in the same cycle;
  - clear cp_valid at that edge;
  - if wb_rd != 0, go to WB; if wb_rd == 0, go to IDLE with no writeback.
- cp_valid must be low by the edge after cp_ready is seen. The coprocessor re-arms one cycle after signalling ready, so a held valid would launch a duplicate operation.
- cp_ready is ignored in IDLE, ISSUE and WB.
- WB: wb_valid=1, and wb_rd/wb_data/wb_err are held stable. When wb_valid && wb_ready, go to IDLE and clear wb_valid and wb_err.
- No acceptance in WB, even when wb_ready=1; a new instruction can be accepted at the earliest one cycle later.
- Latency: accept edge to cp_valid is 1 cycle. cp_ready sampled to wb_valid is 1 cycle.
- Minimum round trip: coprocessor answers 1 cycle after cp_valid, giving wb_valid 3 cycles after accept.
- cp_func/cp_op1/cp_op2 retain their last values in IDLE. Nothing may depend on them there.

Optional Feature:
- Macro: COPROC_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle without cp_ready.
  - When it reaches TIMEOUT_CYCLES-1 without cp_ready: clear cp_valid, set wb_data=32'hFFFF_FFFF and wb_err=1, and go to WB. If wb_rd==0, go to IDLE instead.
  - cp_ready arriving on the same cycle as the limit wins: the normal result is captured with wb_err=0.
  - This covers divides that the coprocessor never completes.
- Undefined: WAIT waits indefinitely, the counter is absent, and wb_err is tied 0.

Test Plan:
1. ex_instr=0x022082B3 (mul x5,x1,x2), rs1=7, rs2=6; coprocessor model pulses cp_ready 3 cycles after cp_valid with cp_result=42 -> cp_func=000, cp_op1=7, cp_op2=6; wb_valid with wb_rd=5, wb_data=42, wb_err=0; cp_valid low the cycle after cp_ready.
2. ex_instr=0x002082B3 (add) with ex_valid=1 -> ex_is_mext=0, ex_ready=0, cp_valid stays 0, busy=0.
3. mulhu x3,x1,x2 (funct3=011), rs1=32'hFFFF_FFFF, rs2=2, cp_result=1 -> cp_func=011, wb_rd=3, wb_data=1; wb_ready held low 5 cycles -> wb_valid/wb_data stable and ex_ready=0 throughout.
4. mul x0,x1,x2 -> one full cp_valid/cp_ready transaction, no wb_valid, busy=0 one cycle after cp_ready is sampled.
5. resetn low for 1 cycle during WAIT -> next cycle cp_valid=0, wb_valid=0, busy=0; a new mul is accepted normally afterwards.
6. COPROC_TIMEOUT_EN, TIMEOUT_CYCLES=16, div with cp_ready never asserted -> cp_valid drops after 16 WAIT cycles; wb_data=32'hFFFF_FFFF, wb_err=1. Without the macro, busy stays 1 for 1000 cycles.
